stream_demux_rr: RTL and testbench

STREAM_DEMUX_RR -- requirements
Module: stream_demux_rr

---
 rtl/stream_demux_rr_if.sv | 38 +++
 rtl/stream_demux_rr.sv | 64 ++++++
 tb/tb_stream_demux_rr.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_rr_if.sv
// Stream bundle for the round-robin demux: one upstream valid/ready stream
// fanning out to N_OUT downstream valid/ready channels plus the routing pointer.
interface stream_demux_rr_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
);
  localparam int PTR_W = $clog2(N_OUT);

  logic                   up_valid;
  logic                   up_ready;
  logic [WIDTH-1:0]       up_data;
  logic [N_OUT-1:0]       dn_valid;
  logic [N_OUT-1:0]       dn_ready;
  logic [N_OUT*WIDTH-1:0] dn_data;
  logic [PTR_W-1:0]       ptr;

  // Producer/consumer side: drives upstream beats and downstream readiness.
  modport master (
    output up_valid,
    output up_data,
    output dn_ready,
    input  up_ready,
    input  dn_valid,
    input  dn_data,
    input  ptr
  );

  // Demux side.
  modport slave (
    input  up_valid,
    input  up_data,
    input  dn_ready,
    output up_ready,
    output dn_valid,
    output dn_data,
    output ptr
  );
endinterface

// File: rtl/stream_demux_rr.sv
// Strict round-robin stream demultiplexer: each accepted beat lands in the
// one-entry output register of channel ptr, then ptr advances to the next channel.
module stream_demux_rr #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_demux_rr_if.slave      bus
);
  localparam int PTR_W = $clog2(N_OUT);

  logic [N_OUT-1:0] valid_q;
  logic [WIDTH-1:0] data_q [N_OUT];
  logic [PTR_W-1:0] ptr_q;
  logic             up_ready;
  logic             up_fire;

  // The input only looks at the channel it is about to fill; other channels
  // drain on their own. While rst is high the state is treated as already cleared.
  always_comb begin
    up_ready = 1'b1;
    if (!rst) begin
      up_ready = !valid_q[ptr_q] || bus.dn_ready[ptr_q];
    end
  end

  assign up_fire = bus.up_valid && up_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      valid_q <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (up_fire && (ptr_q == PTR_W'(k))) begin
          data_q[k]  <= bus.up_data;
          valid_q[k] <= 1'b1;
        end else if (bus.dn_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (up_fire) begin
        ptr_q <= ptr_q + PTR_W'(1);
      end
    end
  end

  assign bus.up_ready = up_ready;
  assign bus.dn_valid = valid_q;
  assign bus.ptr      = ptr_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign bus.dn_data[g*WIDTH +: WIDTH] = data_q[g];

    // A stalled beat must not move or vanish.
    assert property (@(posedge clk) disable iff (rst)
      (valid_q[g] && !bus.dn_ready[g]) |=> (valid_q[g] && $stable(data_q[g])));
  end

endmodule

// File: tb/tb_stream_demux_rr.sv
// Self-checking bench for stream_demux_rr: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a sequence-based model.
module tb_stream_demux_rr;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  stream_demux_rr_if #(.WIDTH(W), .N_OUT(N)) bus ();

  stream_demux_rr #(.WIDTH(W), .N_OUT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic uv, input logic [W-1:0] ud, input logic [N-1:0] dr);
    @(posedge clk);
    #1;
    bus.up_valid = uv;
    bus.up_data  = ud;
    bus.dn_ready = dr;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    bus.dn_ready = '1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Model: beat n accepted since reset belongs to channel n % N. A channel holds
  // a beat while it has received more beats than it has handed downstream.
  logic [W-1:0] sent [$];
  int           total;
  int           cons [N];

  function automatic int accepted(input int k);
    return (total + N - 1 - k) / N;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] ev;
    logic [W-1:0] ed;
    logic         eur;
    int           a;
    if (rst) begin
      checkOutput("reset_up_ready", {31'b0, bus.up_ready}, 32'd1);
      sent.delete();
      total = 0;
      for (int k = 0; k < N; k++) cons[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        a     = accepted(k);
        ev[k] = (a > cons[k]);
        ed    = (a > 0) ? sent[k + (a - 1) * N] : '0;
        checkOutput($sformatf("model_dn_data%0d", k), {24'b0, bus.dn_data[k*W +: W]}, {24'b0, ed});
      end
      eur = !ev[total % N] || bus.dn_ready[total % N];
      checkOutput("model_dn_valid", {28'b0, bus.dn_valid}, {28'b0, ev});
      checkOutput("model_ptr", {30'b0, bus.ptr}, total % N);
      checkOutput("model_up_ready", {31'b0, bus.up_ready}, {31'b0, eur});
      for (int k = 0; k < N; k++) begin
        if (ev[k] && bus.dn_ready[k]) cons[k]++;
      end
      if (bus.up_valid && eur) begin
        sent.push_back(bus.up_data);
        total++;
      end
    end
  end

  initial begin
    int drained;
    bus.up_valid = 1'b0;
    bus.up_data  = '0;
    bus.dn_ready = '1;

    // Back-to-back beats with every consumer ready.
    doReset();
    #2;
    checkOutput("rst_ptr", {30'b0, bus.ptr}, 32'd0);
    checkOutput("rst_dn_valid", {28'b0, bus.dn_valid}, 32'd0);
    checkOutput("rst_dn_data", bus.dn_data, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, W'(8'h10 + i), 4'hF);
      #2;
      checkOutput($sformatf("b2b_ptr%0d", i), {30'b0, bus.ptr}, i % 4);
      checkOutput($sformatf("b2b_up_ready%0d", i), {31'b0, bus.up_ready}, 32'd1);
      if (i > 0) begin
        checkOutput($sformatf("b2b_valid%0d", i), {28'b0, bus.dn_valid}, 32'd1 << ((i - 1) % 4));
        checkOutput($sformatf("b2b_data%0d", i), {24'b0, bus.dn_data[((i-1)%4)*W +: W]}, 32'h10 + i - 1);
      end
    end
    applyStimulus(1'b0, 8'h00, 4'hF);
    #2;
    checkOutput("b2b_ptr_end", {30'b0, bus.ptr}, 32'd0);
    checkOutput("b2b_valid_end", {28'b0, bus.dn_valid}, 32'h8);
    checkOutput("b2b_data_end", {24'b0, bus.dn_data[3*W +: W]}, 32'h17);

    // Channel 0 stalls; the input must wait for it rather than skip ahead.
    doReset();
    applyStimulus(1'b1, 8'hA0, 4'b1110);
    applyStimulus(1'b1, 8'hA1, 4'b1110);
    applyStimulus(1'b1, 8'hA2, 4'b1110);
    applyStimulus(1'b1, 8'hA3, 4'b1110);
    applyStimulus(1'b1, 8'hA4, 4'b1110);
    #2;
    checkOutput("stall_ptr", {30'b0, bus.ptr}, 32'd0);
    checkOutput("stall_up_ready", {31'b0, bus.up_ready}, 32'd0);
    checkOutput("stall_valid0", {31'b0, bus.dn_valid[0]}, 32'd1);
    applyStimulus(1'b1, 8'hA4, 4'b1110);
    #2;
    checkOutput("stall_hold_ptr", {30'b0, bus.ptr}, 32'd0);
    checkOutput("stall_hold_data0", {24'b0, bus.dn_data[0 +: W]}, 32'hA0);
    applyStimulus(1'b1, 8'hA4, 4'b1111);
    #2;
    checkOutput("stall_release_up_ready", {31'b0, bus.up_ready}, 32'd1);
    applyStimulus(1'b0, 8'h00, 4'b1110);
    #2;
    checkOutput("reload_data0", {24'b0, bus.dn_data[0 +: W]}, 32'hA4);
    checkOutput("reload_valid0", {31'b0, bus.dn_valid[0]}, 32'd1);
    checkOutput("reload_ptr", {30'b0, bus.ptr}, 32'd1);

    // Channel 2 blocked for five cycles holds its beat steady.
    doReset();
    applyStimulus(1'b1, 8'h01, 4'hF);
    applyStimulus(1'b1, 8'h02, 4'hF);
    applyStimulus(1'b1, 8'h55, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 4'b1011);
      #2;
      checkOutput($sformatf("hold_data2_%0d", i), {24'b0, bus.dn_data[2*W +: W]}, 32'h55);
      checkOutput($sformatf("hold_valid2_%0d", i), {31'b0, bus.dn_valid[2]}, 32'd1);
    end

    // Reset with channels 0 and 1 full and ptr at 2 discards both beats.
    doReset();
    applyStimulus(1'b1, 8'h31, 4'b1100);
    applyStimulus(1'b1, 8'h32, 4'b1100);
    applyStimulus(1'b0, 8'h00, 4'b1100);
    #2;
    checkOutput("prerst_ptr", {30'b0, bus.ptr}, 32'd2);
    checkOutput("prerst_valid", {28'b0, bus.dn_valid}, 32'h3);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.up_valid = 1'b1;
    bus.up_data  = 8'h77;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.up_valid = 1'b0;
    bus.dn_ready = 4'hF;
    #1;
    checkOutput("postrst_ptr", {30'b0, bus.ptr}, 32'd0);
    checkOutput("postrst_valid", {28'b0, bus.dn_valid}, 32'd0);
    checkOutput("postrst_data", bus.dn_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 4'hF);
      #2;
      checkOutput($sformatf("postrst_quiet%0d", i), {28'b0, bus.dn_valid}, 32'd0);
    end

    // Randomized traffic against the model, then drain everything.
    doReset();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), N'($urandom));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 4'hF);
    #2;
    drained = 0;
    for (int k = 0; k < N; k++) drained += cons[k];
    checkOutput("rand_all_drained", drained, total);
    checkOutput("rand_dn_valid_empty", {28'b0, bus.dn_valid}, 32'd0);
    checkOutput("rand_traffic_seen", {31'b0, (total > 100)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
